// File: rtl/ps2_keys_pkg.sv
// Shared scan-code constants, decoder state encoding and key-to-action map
// for the PS/2 cursor controller.
package ps2_keys_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_DOWN  = 8'h72;

    typedef enum logic [1:0] {
        DEC_IDLE,
        DEC_EXT,
        DEC_BRK,
        DEC_EXT_BRK
    } dec_state_e;

    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_INC,
        ACT_DEC,
        ACT_SEL
    } action_e;

    function automatic action_e key_action(input logic ext, input logic [7:0] code);
        action_e act;
        act = ACT_NONE;
        if (!ext) begin
            case (code)
                KEY_W, KEY_D:         act = ACT_INC;
                KEY_S, KEY_A:         act = ACT_DEC;
                KEY_ENTER, KEY_SPACE: act = ACT_SEL;
                default:              act = ACT_NONE;
            endcase
        end else begin
            case (code)
                KEY_RIGHT, KEY_UP:    act = ACT_INC;
                KEY_LEFT, KEY_DOWN:   act = ACT_DEC;
                default:              act = ACT_NONE;
            endcase
        end
        return act;
    endfunction

endpackage

// File: rtl/ps2_cursor_ctrl_if.sv
// Decoded key-event channel between the scan-code decoder and the cursor logic.
interface ps2_cursor_ctrl_if;

    logic       evt_valid;
    logic       evt_make;
    logic       evt_ext;
    logic [7:0] evt_code;

    modport master (
        output evt_valid,
        output evt_make,
        output evt_ext,
        output evt_code
    );

    modport slave (
        input evt_valid,
        input evt_make,
        input evt_ext,
        input evt_code
    );

endinterface

// File: rtl/ps2_code_decoder.sv
// PS/2 prefix FSM: folds E0/F0 prefixes into one registered make/break event
// per completed sequence.
module ps2_code_decoder
    import ps2_keys_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             code_valid,
    input  logic [7:0]       code,
    ps2_cursor_ctrl_if.master evt
);

    dec_state_e state_q, state_d;
    logic       evt_valid_q, evt_valid_d;
    logic       evt_make_q,  evt_make_d;
    logic       evt_ext_q,   evt_ext_d;
    logic [7:0] evt_code_q,  evt_code_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= DEC_IDLE;
            evt_valid_q <= 1'b0;
            evt_make_q  <= 1'b0;
            evt_ext_q   <= 1'b0;
            evt_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            evt_valid_q <= evt_valid_d;
            evt_make_q  <= evt_make_d;
            evt_ext_q   <= evt_ext_d;
            evt_code_q  <= evt_code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (code_valid) begin
            case (state_q)
                DEC_IDLE: begin
                    if (code == PS2_EXT)      state_d = DEC_EXT;
                    else if (code == PS2_BRK) state_d = DEC_BRK;
                    else                      state_d = DEC_IDLE;
                end
                DEC_EXT:     state_d = (code == PS2_BRK) ? DEC_EXT_BRK : DEC_IDLE;
                DEC_BRK:     state_d = DEC_IDLE;
                DEC_EXT_BRK: state_d = DEC_IDLE;
                default:     state_d = DEC_IDLE;
            endcase
        end
    end

    always_comb begin
        evt_valid_d = 1'b0;
        evt_make_d  = 1'b0;
        evt_ext_d   = 1'b0;
        evt_code_d  = code;
        if (code_valid) begin
            case (state_q)
                DEC_IDLE: begin
                    evt_valid_d = (code != PS2_EXT) && (code != PS2_BRK);
                    evt_make_d  = 1'b1;
                end
                DEC_EXT: begin
                    evt_valid_d = (code != PS2_BRK);
                    evt_make_d  = 1'b1;
                    evt_ext_d   = 1'b1;
                end
                DEC_BRK: begin
                    evt_valid_d = 1'b1;
                end
                DEC_EXT_BRK: begin
                    evt_valid_d = 1'b1;
                    evt_ext_d   = 1'b1;
                end
                default: evt_valid_d = 1'b0;
            endcase
        end
    end

    assign evt.evt_valid = evt_valid_q;
    assign evt.evt_make  = evt_make_q;
    assign evt.evt_ext   = evt_ext_q;
    assign evt.evt_code  = evt_code_q;

endmodule

// File: rtl/ps2_cursor_ctrl.sv
// Keyboard-driven cursor/selection controller: key map, held-key tracking,
// wrap/saturate cursor arithmetic over a run-time list size, and clamping.
module ps2_cursor_ctrl
    import ps2_keys_pkg::*;
#(
    parameter int unsigned W         = 5,
    parameter bit          WRAP      = 1'b1,
    parameter bit          REPEAT_EN = 1'b0,
    parameter int unsigned RESET_POS = 0
) (
    input  logic         CLOCK_50,
    input  logic         i_rst_n,
    input  logic         i_code_valid,
    input  logic [7:0]   i_code,
    input  logic [W:0]   i_max,
    output logic [W-1:0] o_cursor,
    output logic         o_select,
    output logic [W-1:0] o_select_idx,
    output logic         o_moved,
    output logic         o_held
);

    localparam logic [W:0] RESET_EXT = (W+1)'(RESET_POS);

    ps2_cursor_ctrl_if evt_if ();

    ps2_code_decoder u_dec (
        .clk        (CLOCK_50),
        .rst_n      (i_rst_n),
        .code_valid (i_code_valid),
        .code       (i_code),
        .evt        (evt_if.master)
    );

    logic [W-1:0] cursor_q,     cursor_d;
    logic [W-1:0] select_idx_q, select_idx_d;
    logic         select_q,     select_d;
    logic         moved_q,      moved_d;
    logic [8:0]   held_q,       held_d;
    logic         held_vld_q,   held_vld_d;

    logic [W:0]   max_m1;
    logic [W:0]   cur_ext;
    logic [W-1:0] clamp_val;
    logic [W-1:0] rst_cursor;
    logic [W-1:0] next_pos;
    logic [8:0]   key;
    logic         held_match;
    action_e      act;
    action_e      run;

    always_ff @(posedge CLOCK_50) begin
        if (!i_rst_n) begin
            cursor_q     <= rst_cursor;
            select_idx_q <= '0;
            select_q     <= 1'b0;
            moved_q      <= 1'b0;
            held_q       <= '0;
            held_vld_q   <= 1'b0;
        end else begin
            cursor_q     <= cursor_d;
            select_idx_q <= select_idx_d;
            select_q     <= select_d;
            moved_q      <= moved_d;
            held_q       <= held_d;
            held_vld_q   <= held_vld_d;
        end
    end

    always_comb begin
        max_m1     = i_max - (W+1)'(1);
        cur_ext    = {1'b0, cursor_q};
        clamp_val  = (i_max == '0) ? '0 : max_m1[W-1:0];
        rst_cursor = (RESET_EXT >= i_max) ? clamp_val : RESET_EXT[W-1:0];
        key        = {evt_if.evt_ext, evt_if.evt_code};
        act        = key_action(evt_if.evt_ext, evt_if.evt_code);
        held_match = held_vld_q && (held_q == key);
    end

    // Held-key tracking decides whether a make code is a fresh press or a typematic repeat.
    always_comb begin
        held_d     = held_q;
        held_vld_d = held_vld_q;
        run        = ACT_NONE;
        if (evt_if.evt_valid) begin
            if (evt_if.evt_make && (act != ACT_NONE)) begin
                if (REPEAT_EN || !held_match) run = act;
                held_d     = key;
                held_vld_d = 1'b1;
            end else if (!evt_if.evt_make && held_match) begin
                held_vld_d = 1'b0;
            end
        end
    end

    always_comb begin
        case (run)
            ACT_INC: next_pos = (cur_ext == max_m1) ? (WRAP ? '0 : cursor_q)
                                                     : cursor_q + W'(1);
            ACT_DEC: next_pos = (cursor_q == '0) ? (WRAP ? max_m1[W-1:0] : '0)
                                                  : cursor_q - W'(1);
            default: next_pos = cursor_q;
        endcase
    end

    // An out-of-range cursor is clamped first; any key action in that cycle is dropped.
    // The clamp also covers an empty list, which pins the cursor at 0 with no pulses.
    always_comb begin
        cursor_d     = cursor_q;
        select_idx_d = select_idx_q;
        select_d     = 1'b0;
        moved_d      = 1'b0;
        if (cur_ext >= i_max) begin
            cursor_d = clamp_val;
        end else if (run == ACT_SEL) begin
            select_d     = 1'b1;
            select_idx_d = cursor_q;
        end else begin
            cursor_d = next_pos;
            moved_d  = (next_pos != cursor_q);
        end
    end

    assign o_cursor     = cursor_q;
    assign o_select     = select_q;
    assign o_select_idx = select_idx_q;
    assign o_moved      = moved_q;
    assign o_held       = held_vld_q;

endmodule

// File: tb/tb_ps2_cursor_ctrl.sv
// Directed bench for ps2_cursor_ctrl: three instances cover wrap, saturate
// and typematic-repeat configurations, each driven by its own inputs.
module tb_ps2_cursor_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cv    [3];
    logic [7:0] code  [3];
    logic [5:0] mx    [3];
    logic [4:0] cur   [3];
    logic       sel   [3];
    logic [4:0] idx   [3];
    logic       moved [3];
    logic       held  [3];

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ps2_cursor_ctrl #(.W(5), .WRAP(1'b1), .REPEAT_EN(1'b0), .RESET_POS(3)) u_wrap (
        .CLOCK_50(clk), .i_rst_n(rst_n), .i_code_valid(cv[0]), .i_code(code[0]),
        .i_max(mx[0]), .o_cursor(cur[0]), .o_select(sel[0]), .o_select_idx(idx[0]),
        .o_moved(moved[0]), .o_held(held[0])
    );

    ps2_cursor_ctrl #(.W(5), .WRAP(1'b0), .REPEAT_EN(1'b0), .RESET_POS(0)) u_sat (
        .CLOCK_50(clk), .i_rst_n(rst_n), .i_code_valid(cv[1]), .i_code(code[1]),
        .i_max(mx[1]), .o_cursor(cur[1]), .o_select(sel[1]), .o_select_idx(idx[1]),
        .o_moved(moved[1]), .o_held(held[1])
    );

    ps2_cursor_ctrl #(.W(5), .WRAP(1'b1), .REPEAT_EN(1'b1), .RESET_POS(0)) u_rep (
        .CLOCK_50(clk), .i_rst_n(rst_n), .i_code_valid(cv[2]), .i_code(code[2]),
        .i_max(mx[2]), .o_cursor(cur[2]), .o_select(sel[2]), .o_select_idx(idx[2]),
        .o_moved(moved[2]), .o_held(held[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [7:0] b);
        cv[d]   = 1'b1;
        code[d] = b;
        @(posedge clk);
        #1;
        cv[d]   = 1'b0;
    endtask

    task automatic press(input int d, input logic ext, input logic [7:0] b);
        if (ext) send(d, 8'hE0);
        send(d, b);
    endtask

    task automatic release_key(input int d, input logic ext, input logic [7:0] b);
        if (ext) send(d, 8'hE0);
        send(d, 8'hF0);
        send(d, b);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cv[i]   = 1'b0;
            code[i] = 8'h00;
        end
        mx[0] = 6'd4;
        mx[1] = 6'd3;
        mx[2] = 6'd4;
        repeat (2) @(posedge clk);
        #1;

        check("rst_cursor_wrap",  32'(cur[0]),   32'd3);
        check("rst_select",       32'(sel[0]),   32'd0);
        check("rst_select_idx",   32'(idx[0]),   32'd0);
        check("rst_moved",        32'(moved[0]), 32'd0);
        check("rst_held",         32'(held[0]),  32'd0);
        check("rst_cursor_sat",   32'(cur[1]),   32'd0);
        check("rst_cursor_rep",   32'(cur[2]),   32'd0);
        rst_n = 1'b1;
        step();

        // Wrap at top, then extended left wraps at bottom
        press(0, 1'b0, 8'h1D); step();
        check("inc_wrap_cursor",  32'(cur[0]),   32'd0);
        check("inc_wrap_moved",   32'(moved[0]), 32'd1);
        step();
        check("moved_one_cycle",  32'(moved[0]), 32'd0);
        press(0, 1'b1, 8'h6B); step();
        check("ext_left_cursor",  32'(cur[0]),   32'd3);
        check("ext_left_moved",   32'(moved[0]), 32'd1);

        // Saturating instance
        press(1, 1'b0, 8'h1B); step();
        check("sat_dec_cursor",   32'(cur[1]),   32'd0);
        check("sat_dec_moved",    32'(moved[1]), 32'd0);
        release_key(1, 1'b0, 8'h1B); step();
        for (int i = 0; i < 3; i++) begin
            press(1, 1'b0, 8'h23); step();
            check("sat_inc_cursor", 32'(cur[1]),   (i == 0) ? 32'd1 : 32'd2);
            check("sat_inc_moved",  32'(moved[1]), (i == 2) ? 32'd0 : 32'd1);
            release_key(1, 1'b0, 8'h23); step();
        end

        // Repeat suppression with REPEAT_EN=0
        release_key(0, 1'b1, 8'h6B); step();
        check("ext_break_held",   32'(held[0]),  32'd0);
        press(0, 1'b0, 8'h1D); step();
        check("first_make_cursor", 32'(cur[0]),  32'd0);
        check("first_make_held",  32'(held[0]),  32'd1);
        press(0, 1'b0, 8'h1D); step();
        check("repeat2_moved",    32'(moved[0]), 32'd0);
        press(0, 1'b0, 8'h1D); step();
        check("repeat3_cursor",   32'(cur[0]),   32'd0);
        check("repeat3_held",     32'(held[0]),  32'd1);
        release_key(0, 1'b0, 8'h1D); step();
        check("break_held",       32'(held[0]),  32'd0);
        press(0, 1'b0, 8'h1D); step();
        check("second_move",      32'(cur[0]),   32'd1);
        check("second_move_pulse", 32'(moved[0]), 32'd1);

        // Typematic repeat moves the cursor with REPEAT_EN=1
        for (int i = 0; i < 3; i++) begin
            press(2, 1'b0, 8'h1D); step();
            check("rep_cursor",   32'(cur[2]),   32'(i + 1));
            check("rep_moved",    32'(moved[2]), 32'd1);
        end
        press(2, 1'b0, 8'h1D); step();
        check("rep_wrap_cursor",  32'(cur[2]),   32'd0);
        press(2, 1'b1, 8'h72); step();
        check("ext_down_wrap",    32'(cur[2]),   32'd3);

        // Select
        release_key(0, 1'b0, 8'h1D); step();
        press(0, 1'b0, 8'h1D); step();
        check("pre_sel_cursor",   32'(cur[0]),   32'd2);
        press(0, 1'b0, 8'h5A); step();
        check("sel_pulse",        32'(sel[0]),   32'd1);
        check("sel_idx",          32'(idx[0]),   32'd2);
        check("sel_no_move",      32'(moved[0]), 32'd0);
        step();
        check("sel_one_cycle",    32'(sel[0]),   32'd0);
        release_key(0, 1'b0, 8'h5A); step();
        check("sel_break_nosel",  32'(sel[0]),   32'd0);
        release_key(0, 1'b1, 8'h75); step();
        check("ext_break_nomove", 32'(moved[0]), 32'd0);
        check("ext_break_cursor", 32'(cur[0]),   32'd2);

        // Clamp beats a move in the same cycle
        mx[1] = 6'd10;
        step();
        for (int i = 0; i < 5; i++) begin
            press(1, 1'b0, 8'h23); step();
            release_key(1, 1'b0, 8'h23); step();
        end
        check("pre_clamp_cursor", 32'(cur[1]),   32'd7);
        send(1, 8'h23);
        mx[1] = 6'd5;
        step();
        check("clamp_cursor",     32'(cur[1]),   32'd4);
        check("clamp_no_moved",   32'(moved[1]), 32'd0);
        mx[1] = 6'd0;
        step();
        check("empty_cursor",     32'(cur[1]),   32'd0);
        press(1, 1'b0, 8'h5A); step();
        check("empty_no_sel",     32'(sel[1]),   32'd0);
        step();
        check("empty_no_sel2",    32'(sel[1]),   32'd0);
        check("empty_cursor2",    32'(cur[1]),   32'd0);

        // Reset discards a pending E0 prefix
        send(0, 8'hE0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        send(0, 8'h75); step();
        check("rst_mid_cursor",   32'(cur[0]),   32'd3);
        check("rst_mid_moved",    32'(moved[0]), 32'd0);
        check("rst_mid_held",     32'(held[0]),  32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_cursor_ctrl.md
# ps2_cursor_ctrl

Parametrised cursor/selection controller for the UNO game. It consumes the one-byte PS/2 scan-code stream from the keyboard receiver and decodes make, break and extended (E0) sequences. It maintains a wrap-around or saturating cursor over a run-time-sized list, such as the cards in the current hand, and emits a one-cycle select strobe. It sits between the keyboard receiver and the game-logic/display blocks.

## Interface
Parameters:
- W, 5: cursor width; list size up to 2^W.
- WRAP, 1: 1 = cursor wraps at both ends; 0 = saturates.
- REPEAT_EN, 0: 1 = typematic repeat make codes move the cursor; 0 = repeats ignored until the key's break code arrives.
- RESET_POS, 0: cursor value after reset.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- i_rst_n  in  1  reset; synchronous, active-low; single clock domain
- i_code_valid  in  1  one-cycle strobe, i_code is a new scan byte
- i_code  in  8  scan-code byte
- i_max  in  W+1  current list size, 0..2^W
- o_cursor  out  W  current cursor index
- o_select  out  1  one-cycle pulse, selection made
- o_select_idx  out  W  index latched at select
- o_moved  out  1  one-cycle pulse, cursor changed by a key
- o_held  out  1  a recognised key is currently held

## Operation
- Decoder FSM states:
  - IDLE: on E0 → EXT; on F0 → BRK; any other byte → make(ext=0), stay IDLE.
  - EXT: on F0 → EXT_BRK; other byte → make(ext=1), → IDLE.
  - BRK: any byte → break(ext=0), → IDLE.
  - EXT_BRK: any byte → break(ext=1), → IDLE.
  - E1 and bytes AA/FA/FE are treated as ordinary codes and match no key, so they are ignored.
- Key map:
  - INC: 1D (W), 23 (D), E0 74 (right), E0 75 (up).
  - DEC: 1B (S), 1C (A), E0 6B (left), E0 72 (down).
  - SEL: 5A (Enter), 29 (Space).
  - All other codes: no action; the decoder still tracks their prefixes.
- Held register: 9 bits {ext, code} plus a valid flag.
  - Make of a mapped key, REPEAT_EN=0: if it equals the held key it is ignored; otherwise the action runs and the held register is loaded.
  - Make of a mapped key, REPEAT_EN=1: the action always runs.
  - Break equal to the held key clears valid. Other breaks are ignored.
- Move arithmetic (m = i_max):
  - INC at m-1: result 0 if WRAP, else stays m-1.
  - DEC at 0: result m-1 if WRAP, else stays 0.
  - Otherwise ±1. Compute in W+1 bits so m = 2^W does not overflow.
- m = 0: INC/DEC/SEL have no effect, cursor forced to 0, no pulses.
- Clamp: if o_cursor ≥ i_max at a clock edge, o_cursor ← max(i_max-1, 0). Clamp has priority over a move in the same cycle; that move is discarded and o_moved stays low.
- SEL (with m ≠ 0): o_select pulses; o_select_idx ← o_cursor.
- o_moved is asserted only if the value actually changed, so a saturating edge gives no pulse.

## Timing
- Reset (i_rst_n low at an edge):
  - FSM → IDLE; held register cleared.
  - o_cursor = RESET_POS clamped by i_max; o_select_idx = 0.
  - o_select = o_moved = o_held = 0.
- Reset takes effect mid-sequence; any partial E0/F0 prefix is discarded.
- Latency: final byte strobe at edge n → o_cursor/o_moved/o_select/o_held valid after edge n+1. Pulses are exactly one cycle.
- Back-to-back strobes on consecutive cycles are accepted. No backpressure.
- i_code is sampled only when i_code_valid = 1.

## Structure
- Package ps2_keys_pkg holds:
  - scan-code constants (PS2_EXT=E0, PS2_BRK=F0, key codes above);
  - decoder state encoding;
  - action enum {NONE, INC, DEC, SEL}.
- Sub-module ps2_code_decoder holds the prefix FSM. Outputs: evt_valid, evt_make, evt_ext, evt_code[7:0].
- The top module holds the key map, held register, cursor arithmetic and clamp.

## Test plan
- W=5, i_max=4, WRAP=1, cursor 3; send 1D → cursor 0, o_moved pulse; send E0 6B → cursor 3.
- WRAP=0, cursor 0; send 1B → cursor stays 0, no o_moved; send 23 ×3 with i_max=3 → cursor 2.
- REPEAT_EN=0; send 1D,1D,1D → one move, o_held=1; send F0 1D → o_held=0; send 1D → second move. REPEAT_EN=1: three moves.
- Cursor 2; send 5A → o_select one cycle later, o_select_idx=2; send F0 5A → no select; send E0 F0 75 → no move.
- Cursor 7, drop i_max 10→5 in the same cycle as an INC make → cursor 4, no o_moved; i_max=0 then SEL → no pulse, cursor 0.
- Send E0, then assert i_rst_n=0 for one edge, then 75 → treated as non-extended 75, no move; cursor = RESET_POS.
